// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential 48/24 restoring divider.
package div_pkg;

  localparam int W_DEF = 24;
  localparam int CNT_W = $clog2(2 * W_DEF);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

endpackage

// File: rtl/sub_w1bit.sv
// (W+1)-bit subtractor; no_borrow doubles as the unsigned a >= b compare.
module sub_w1bit #(
  parameter int W = 24
) (
  input  logic [W:0] a,
  input  logic [W:0] b,
  output logic [W:0] diff,
  output logic       no_borrow
);

  logic borrow;

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};
  assign no_borrow      = ~borrow;

endmodule

// File: rtl/div48by24_seq.sv
// Sequential restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per clock.
// Optional sticky output (|remainder) enabled by defining DIV48BY24_STICKY_EN.
module div48by24_seq
  import div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] quotient,
  output logic [W-1:0]   remainder,
`ifdef DIV48BY24_STICKY_EN
  output logic           sticky,
`endif
  output logic           div_by_zero
);

  localparam int CW = $clog2(2 * W);

  div_state_t     state_q, state_d;
  logic [2*W-1:0] q_q;
  logic [W-1:0]   d_q;
  logic [W-1:0]   r_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] quotient_q;
  logic [W-1:0]   remainder_q;
  logic           dbz_q;

  logic [W:0]     t;
  logic [W:0]     diff;
  logic           no_borrow;
  logic [W-1:0]   r_next;
  logic [2*W-1:0] q_next;
  logic           unused_diff_msb;

  assign t = {r_q, q_q[2*W-1]};

  sub_w1bit #(.W(W)) u_sub (
    .a         (t),
    .b         ({1'b0, d_q}),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  // When the subtraction is taken, T < 2D so the difference fits in W bits.
  assign unused_diff_msb = diff[W];
  assign r_next = no_borrow ? diff[W-1:0] : t[W-1:0];
  assign q_next = {q_q[2*W-2:0], no_borrow};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (divisor == '0) ? DONE : RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              q_q   <= dividend;
              d_q   <= divisor;
              r_q   <= '0;
              cnt_q <= CW'(2 * W - 1);
              dbz_q <= 1'b0;
            end else begin
              quotient_q  <= '1;
              remainder_q <= '0;
              dbz_q       <= 1'b1;
            end
          end
        end
        RUN: begin
          q_q   <= q_next;
          r_q   <= r_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            quotient_q  <= q_next;
            remainder_q <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV48BY24_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      sticky_q <= 1'b0;
    else if (state_q == IDLE && start && divisor == '0)
      sticky_q <= 1'b0;
    else if (state_q == RUN && cnt_q == '0)
      sticky_q <= |r_next;
  end

  assign sticky = sticky_q;
`endif

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div48by24_seq.sv
// Self-checking bench for div48by24_seq against a plain-arithmetic division model.
// Define DIV48BY24_STICKY_EN to also check the sticky output.
module tb_div48by24_seq;

  localparam int W = 24;
  localparam int LAT = 2 * W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*W-1:0] quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
`ifdef DIV48BY24_STICKY_EN
  logic           sticky;
`endif

  int n_checks = 0;
  int n_errors = 0;

  div48by24_seq #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
`ifdef DIV48BY24_STICKY_EN
    .sticky      (sticky),
`endif
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait for done; optionally re-assert start mid-run.
  task automatic do_op(input logic [2*W-1:0] a, input logic [W-1:0] b, input bit reassert,
                       output int lat, output bit busy_all);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat      = 0;
    busy_all = busy;
    while (!done && lat < 200) begin
      if (reassert && lat == 10) begin
        start    = 1'b1;
        dividend = 48'd5;
      end
      if (reassert && lat == 11) start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      busy_all = busy_all & busy;
    end
  endtask

  // Compare results against plain division and check done drops after one cycle.
  task automatic check_result(input string tag, input logic [2*W-1:0] a, input logic [W-1:0] b,
                              input int lat);
    logic [2*W-1:0] exp_q;
    logic [W-1:0]   exp_r;
    logic           exp_dz;
    if (b == '0) begin
      exp_q  = '1;
      exp_r  = '0;
      exp_dz = 1'b1;
    end else begin
      exp_q  = a / {24'd0, b};
      exp_r  = W'(a % {24'd0, b});
      exp_dz = 1'b0;
    end
    check({tag, "_latency"}, 64'(lat), (b == '0) ? 64'd0 : 64'(LAT));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_quotient"}, 64'(quotient), 64'(exp_q));
    check({tag, "_remainder"}, 64'(remainder), 64'(exp_r));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dz));
`ifdef DIV48BY24_STICKY_EN
    check({tag, "_sticky"}, 64'(sticky), 64'(exp_r != '0));
`endif
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat;
    bit busy_all;
    int seen;
    logic [2*W-1:0] a;
    logic [W-1:0]   b;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_quotient", 64'(quotient), 64'd0);
    check("reset_remainder", 64'(remainder), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    do_op(48'h000000000006, 24'h000003, 1'b0, lat, busy_all);
    check("six_by_three_busy", 64'(busy_all), 64'd1);
    check_result("six_by_three", 48'h000000000006, 24'h000003, lat);

    do_op(48'hFFFFFFFFFFFF, 24'hFFFFFF, 1'b0, lat, busy_all);
    check_result("all_ones", 48'hFFFFFFFFFFFF, 24'hFFFFFF, lat);
    check("all_ones_q_const", 64'(quotient), 64'h000001000001);

    do_op(48'd100, 24'd7, 1'b1, lat, busy_all);
    check_result("restart_ignored", 48'd100, 24'd7, lat);
    seen = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("restart_no_second_done", 64'(seen), 64'd0);

    do_op(48'h123, 24'd0, 1'b0, lat, busy_all);
    check_result("div_zero", 48'h123, 24'd0, lat);
    do_op(48'd9, 24'd3, 1'b0, lat, busy_all);
    check_result("after_zero", 48'd9, 24'd3, lat);

    // Abort an operation part-way through the run with a one-edge reset.
    @(negedge clk);
    start    = 1'b1;
    dividend = 48'd1000000;
    divisor  = 24'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_quotient", 64'(quotient), 64'd0);
    check("abort_remainder", 64'(remainder), 64'd0);
    check("abort_dbz", 64'(div_by_zero), 64'd0);
    seen = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    do_op(48'd49, 24'd5, 1'b0, lat, busy_all);
    check_result("after_abort", 48'd49, 24'd5, lat);

    for (int i = 0; i < 1000; i++) begin
      a = {16'($urandom), 32'($urandom)} >> $urandom_range(0, 47);
      b = 24'($urandom) >> $urandom_range(0, 23);
      if (b == '0) b = 24'd1;
      do_op(a, b, 1'b0, lat, busy_all);
      check("rand_invariant", 64'(quotient) * 64'(divisor) + 64'(remainder), 64'(a));
      check("rand_rem_lt_div", 64'(remainder < b), 64'd1);
      check_result("rand", a, b, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
